wb_write_arbiter: RTL

//  Writeback-side initiator for the register-file write port (WE3/A3/WD3).

---
 rtl/wb_write_arbiter.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/wb_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wb_write_arbiter
// Description : Merges a priority ALU result stream and a FIFO-buffered
//               long-latency result stream onto one registered regfile port.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_write_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_REGS     = 32,
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          alu_valid,
    output logic                          alu_ready,
    input  logic [$clog2(NUM_REGS)-1:0]   alu_rd,
    input  logic [DATA_WIDTH-1:0]         alu_data,
    input  logic                          ll_valid,
    output logic                          ll_ready,
    input  logic [$clog2(NUM_REGS)-1:0]   ll_rd,
    input  logic [DATA_WIDTH-1:0]         ll_data,
    output logic                          we,
    output logic [$clog2(NUM_REGS)-1:0]   waddr,
    output logic [DATA_WIDTH-1:0]         wdata,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int C_AW = $clog2(NUM_REGS);
    localparam int C_PW = $clog2(FIFO_DEPTH);
    localparam int C_CW = C_PW + 1;
    localparam int C_SW = $clog2(STARVE_LIMIT) + 1;

    localparam logic [C_SW-1:0] C_STARVE_MAX = C_SW'(STARVE_LIMIT - 1);
    localparam logic [C_CW-1:0] C_FULL       = C_CW'(FIFO_DEPTH);

    localparam logic [0:0] C_ST_NORMAL = 1'b0;
    localparam logic [0:0] C_ST_FORCE  = 1'b1;

    logic [0:0]            r_state;
    logic [0:0]            w_state_next;

    logic [C_PW-1:0]       r_wr_ptr;
    logic [C_PW-1:0]       r_rd_ptr;
    logic [C_CW-1:0]       r_count;
    logic [C_SW-1:0]       r_starve;

    logic [FIFO_DEPTH-1:0] r_live;
    logic [C_AW-1:0]       r_mem_rd   [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] r_mem_data [FIFO_DEPTH];

    logic                  r_we;
    logic [C_AW-1:0]       r_waddr;
    logic [DATA_WIDTH-1:0] r_wdata;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_alu_xfer;
    logic                  w_push;
    logic                  w_pop;

    assign w_full     = (r_count == C_FULL);
    assign w_empty    = (r_count == '0);
    assign ll_ready   = !rst && !w_full;
    assign w_alu_xfer = alu_valid && alu_ready;
    // x0 writes from the long-latency side are accepted but never buffered.
    assign w_push     = ll_valid && ll_ready && (ll_rd != '0);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= C_ST_NORMAL;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            C_ST_NORMAL: begin
                if ((r_starve == C_STARVE_MAX) && !w_empty && !w_pop) begin
                    w_state_next = C_ST_FORCE;
                end
            end
            default: w_state_next = C_ST_NORMAL;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        alu_ready = 1'b0;
        w_pop     = 1'b0;
        case (r_state)
            C_ST_NORMAL: begin
                alu_ready = !rst;
                w_pop     = !w_empty && !(alu_valid && !rst);
            end
            default: begin
                w_pop = !w_empty;
            end
        endcase
    end

    // ---------------- FIFO bookkeeping ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_starve <= '0;
            r_live   <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + C_CW'(1);
                2'b01:   r_count <= r_count - C_CW'(1);
                default: r_count <= r_count;
            endcase

            if (w_pop || w_empty) begin
                r_starve <= '0;
            end else if (r_starve != C_STARVE_MAX) begin
                r_starve <= r_starve + C_SW'(1);
            end

            // A younger ALU write kills older buffered writes to the same
            // register; the push below overrides for the entry entering now.
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                if (w_alu_xfer && (alu_rd != '0) && (r_mem_rd[i] == alu_rd)) begin
                    r_live[i] <= 1'b0;
                end
            end
            if (w_push) begin
                r_live[r_wr_ptr] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_rd[r_wr_ptr]   <= ll_rd;
            r_mem_data[r_wr_ptr] <= ll_data;
        end
    end

    // ---------------- Registered write port ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
        end else begin
            r_we <= 1'b0;
            if (w_alu_xfer) begin
                if (alu_rd != '0) begin
                    r_we    <= 1'b1;
                    r_waddr <= alu_rd;
                    r_wdata <= alu_data;
                end
            end else if (w_pop && r_live[r_rd_ptr]) begin
                r_we    <= 1'b1;
                r_waddr <= r_mem_rd[r_rd_ptr];
                r_wdata <= r_mem_data[r_rd_ptr];
            end
        end
    end

    assign we         = r_we;
    assign waddr      = r_waddr;
    assign wdata      = r_wdata;
    assign fifo_count = r_count;

endmodule
`default_nettype wire
